// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: signal bundle between a multiplexed 7-segment bus
// (and its test harness) and the scan decoder.
//
// Signalling: there is no valid/ready pair here. seg_in/an_in are sampled
// every clock with no back-pressure. new_digit is a one-cycle strobe that is
// coincident with the data_out/digit_valid update it announces. clear is a
// level sampled on the clock edge. fsm_state mirrors the decoder FSM for
// debug and checker binding: 0=IDLE, 1=TRACK, 2=CAPTURE, 3=HOLD.
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   an_in;
    logic                clear;
    logic [4*DIGITS-1:0] data_out;
    logic [DIGITS-1:0]   digit_valid;
    logic                frame_valid;
    logic                new_digit;
    logic                code_err;
    logic [1:0]          fsm_state;

    // Display side / harness: drives the bus and clear, observes results
    modport master (
        output seg_in,
        output an_in,
        output clear,
        input  data_out,
        input  digit_valid,
        input  frame_valid,
        input  new_digit,
        input  code_err,
        input  fsm_state
    );

    // Decoder side
    modport slave (
        input  seg_in,
        input  an_in,
        input  clear,
        output data_out,
        output digit_valid,
        output frame_valid,
        output new_digit,
        output code_err,
        output fsm_state
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex nibbles from a time-multiplexed,
// active-low 7-segment display bus (segments {g,f,e,d,c,b,a} + one-hot-low
// anodes). Each digit slot must be stable for STABLE_CYCLES samples before
// it is decoded into data_out; blanks invalidate a digit, unknown patterns
// raise a sticky code_err.
//
// Build option: define SEG7_INPUT_SYNC_EN to pass seg_in/an_in through a
// 2-flop synchroniser (reset to all-ones) before sampling; this adds two
// cycles of capture latency and is meant for asynchronous/off-chip buses.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_decoder_if.slave bus
);
    localparam int         IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACK   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input path (optionally synchronised)
    // ------------------------------------------------------------------
    logic [6:0]        seg_s;
    logic [DIGITS-1:0] an_s;

`ifdef SEG7_INPUT_SYNC_EN
    logic [6:0]        seg_meta_q;
    logic [6:0]        seg_sync_q;
    logic [DIGITS-1:0] an_meta_q;
    logic [DIGITS-1:0] an_sync_q;

    // Two-flop synchroniser; resets to all-ones, i.e. a dark display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_q <= '1;
            seg_sync_q <= '1;
            an_meta_q  <= '1;
            an_sync_q  <= '1;
        end else begin
            seg_meta_q <= bus.seg_in;
            seg_sync_q <= seg_meta_q;
            an_meta_q  <= bus.an_in;
            an_sync_q  <= an_meta_q;
        end
    end

    assign seg_s = seg_sync_q;
    assign an_s  = an_sync_q;
`else
    assign seg_s = bus.seg_in;
    assign an_s  = bus.an_in;
`endif

    // ------------------------------------------------------------------
    // Sample register and stability counter
    // ------------------------------------------------------------------
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] an_q;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic              changed;
    logic              an_onehot;

    // True when exactly one anode line is driven low
    function automatic logic onehot_low(input logic [DIGITS-1:0] an);
        int unsigned zeros;
        zeros = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

    // Compare the incoming sample with the held one and advance the run length
    always_comb begin
        changed   = ({seg_s, an_s} != {seg_q, an_q});
        an_onehot = onehot_low(an_s);
        cnt_d     = cnt_q;
        if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q < STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Register the sample every cycle; clear only restarts the run count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            an_q  <= '0;
            cnt_q <= '0;
        end else if (bus.clear) begin
            cnt_q <= '0;
        end else begin
            seg_q <= seg_s;
            an_q  <= an_s;
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   capture_en;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: any change of the sample restarts tracking (or drops to
    // IDLE if the anodes are no longer one-hot); a run that reaches
    // STABLE_CYCLES is captured exactly once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (an_onehot) state_d = S_TRACK;
            end
            S_TRACK: begin
                if (changed)                   state_d = an_onehot ? S_TRACK : S_IDLE;
                else if (cnt_d == STABLE_MAX)  state_d = S_CAPTURE;
            end
            S_CAPTURE, S_HOLD: begin
                if (changed) state_d = an_onehot ? S_TRACK : S_IDLE;
                else         state_d = S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.clear) state_d = S_IDLE;
    end

    // FSM outputs: the capture strobe and the debug state view
    always_comb begin
        capture_en    = (state_q == S_CAPTURE);
        bus.fsm_state = state_q;
    end

    // ------------------------------------------------------------------
    // Pattern decode and digit selection (from the held, stable sample)
    // ------------------------------------------------------------------
    logic          dec_hit;
    logic          dec_blank;
    logic [3:0]    dec_nib;
    logic [IW-1:0] digit_idx;

    // Map the active-low segment pattern back to its hex nibble
    always_comb begin
        dec_hit   = 1'b1;
        dec_nib   = 4'h0;
        dec_blank = (seg_q == 7'h7F);
        case (seg_q)
            7'h40:   dec_nib = 4'h0;
            7'h79:   dec_nib = 4'h1;
            7'h24:   dec_nib = 4'h2;
            7'h30:   dec_nib = 4'h3;
            7'h19:   dec_nib = 4'h4;
            7'h12:   dec_nib = 4'h5;
            7'h02:   dec_nib = 4'h6;
            7'h78:   dec_nib = 4'h7;
            7'h00:   dec_nib = 4'h8;
            7'h10:   dec_nib = 4'h9;
            7'h08:   dec_nib = 4'hA;
            7'h03:   dec_nib = 4'hB;
            7'h27:   dec_nib = 4'hC;
            7'h21:   dec_nib = 4'hD;
            7'h06:   dec_nib = 4'hE;
            7'h0E:   dec_nib = 4'hF;
            default: dec_hit = 1'b0;
        endcase
    end

    // Position of the low anode; only meaningful while capturing (one-hot)
    always_comb begin
        digit_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) digit_idx = IW'(i);
        end
    end

    // ------------------------------------------------------------------
    // Recovered value registers
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   valid_q;
    logic                new_digit_q;
    logic                err_q;

    // Apply a capture to the selected digit; clear wins over a capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= '0;
            new_digit_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (bus.clear) begin
            data_q      <= '0;
            valid_q     <= '0;
            new_digit_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            new_digit_q <= 1'b0;
            if (capture_en) begin
                if (dec_hit) begin
                    data_q[{digit_idx, 2'b00} +: 4] <= dec_nib;
                    valid_q[digit_idx]              <= 1'b1;
                    new_digit_q                     <= 1'b1;
                end else if (dec_blank) begin
                    valid_q[digit_idx] <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out    = data_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_valid = &valid_q;
    assign bus.new_digit   = new_digit_q;
    assign bus.code_err    = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed table, hand-written corner sequences and a
// randomised run, all compared against a run-length reference model.
module tb_seg7_scan_decoder;
    localparam int DIG = 4;
    localparam int STB = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.DIGITS(DIG)) bus ();

    seg7_scan_decoder #(
        .DIGITS       (DIG),
        .STABLE_CYCLES(STB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The model watches the stream of presented inputs: a value presented
    // for exactly STB consecutive cycles with a single low anode is applied
    // on the following edge. Glyph table index == decoded nibble.
    logic [6:0]       seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    logic [4*DIG-1:0] m_data;
    logic [DIG-1:0]   m_valid;
    logic             m_err;
    logic             m_new;
    int               m_run;
    logic             m_pend;
    logic [6:0]       m_pseg;
    logic [DIG-1:0]   m_pan;
    logic [6+DIG:0]   m_prev;
    logic             m_have_prev;

    function automatic int count_zeros(input logic [DIG-1:0] a);
        int z = 0;
        for (int i = 0; i < DIG; i++) if (a[i] == 1'b0) z++;
        return z;
    endfunction

    task automatic model_reset();
        m_data = '0; m_valid = '0; m_err = 1'b0; m_new = 1'b0;
        m_run = 0; m_pend = 1'b0; m_have_prev = 1'b0;
        m_pseg = '0; m_pan = '0; m_prev = '0;
    endtask

    task automatic model_capture();
        int k;
        int hit;
        k = 0;
        hit = -1;
        for (int i = 0; i < DIG; i++) if (m_pan[i] == 1'b0) k = i;
        for (int j = 0; j < 16; j++) if (seg_tab[j] == m_pseg) hit = j;
        if (hit >= 0) begin
            m_data[k*4 +: 4] = 4'(hit);
            m_valid[k] = 1'b1;
            m_new = 1'b1;
        end else if (m_pseg == 7'h7F) begin
            m_valid[k] = 1'b0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic model_edge(input logic [6:0] s, input logic [DIG-1:0] a, input logic c);
        m_new = 1'b0;
        if (c) begin
            m_data = '0; m_valid = '0; m_err = 1'b0; m_run = 0; m_pend = 1'b0;
        end else begin
            if (m_pend) model_capture();
            m_pend = 1'b0;
            if (m_have_prev && ({s, a} == m_prev)) m_run++;
            else m_run = 1;
            m_prev = {s, a};
            m_have_prev = 1'b1;
            if (m_run == STB && count_zeros(a) == 1) begin
                m_pend = 1'b1;
                m_pseg = s;
                m_pan  = a;
            end
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, advance the model on the edge, check #1 later
    task automatic step(input logic [6:0] s, input logic [DIG-1:0] a, input logic c);
        bus.seg_in = s;
        bus.an_in  = a;
        bus.clear  = c;
        @(posedge clk);
        model_edge(s, a, c);
        #1;
        check("model_data_out",    bus.data_out,    m_data);
        check("model_digit_valid", bus.digit_valid, m_valid);
        check("model_frame_valid", bus.frame_valid, (m_valid == '1));
        check("model_new_digit",   bus.new_digit,   m_new);
        check("model_code_err",    bus.code_err,    m_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"},    bus.data_out,    16'h0000);
        check({tag, "_digit_valid"}, bus.digit_valid, 4'h0);
        check({tag, "_frame_valid"}, bus.frame_valid, 1'b0);
        check({tag, "_new_digit"},   bus.new_digit,   1'b0);
        check({tag, "_code_err"},    bus.code_err,    1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [6:0]     seg;
        logic [DIG-1:0] an;
        logic           clr;
        int             hold;
        logic [15:0]    e_data;
        logic [3:0]     e_valid;
        logic           e_frame;
        logic           e_err;
        int             e_pulses;
    } vec_t;

    vec_t vecs[$];

    // Watchdog: the run is bounded by clock steps, this only guards a stall
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int pulses;

        // Each row continues from the state left by the previous row
        vecs.push_back('{7'h40, 4'b1110, 1'b0, 10, 16'h0000, 4'b0001, 1'b0, 1'b0, 1});
        vecs.push_back('{7'h79, 4'b1101, 1'b0, 10, 16'h0010, 4'b0011, 1'b0, 1'b0, 1});
        vecs.push_back('{7'h08, 4'b1011, 1'b0, 10, 16'h0A10, 4'b0111, 1'b0, 1'b0, 1});
        vecs.push_back('{7'h0E, 4'b0111, 1'b0, 10, 16'hFA10, 4'b1111, 1'b1, 1'b0, 1});
        vecs.push_back('{7'h30, 4'b1101, 1'b0,  5, 16'hFA10, 4'b1111, 1'b1, 1'b0, 0});
        vecs.push_back('{7'h19, 4'b1101, 1'b0, 10, 16'hFA40, 4'b1111, 1'b1, 1'b0, 1});
        vecs.push_back('{7'h00, 4'b1100, 1'b0, 20, 16'hFA40, 4'b1111, 1'b1, 1'b0, 0});
        vecs.push_back('{7'h7F, 4'b0111, 1'b0, 10, 16'hFA40, 4'b0111, 1'b0, 1'b0, 0});
        vecs.push_back('{7'h06, 4'b0111, 1'b0, 10, 16'hEA40, 4'b1111, 1'b1, 1'b0, 1});
        vecs.push_back('{7'h7F, 4'b1111, 1'b0,  2, 16'hEA40, 4'b1111, 1'b1, 1'b0, 0});
        vecs.push_back('{7'h06, 4'b0111, 1'b0, 10, 16'hEA40, 4'b1111, 1'b1, 1'b0, 1});
        vecs.push_back('{7'h55, 4'b1011, 1'b0, 10, 16'hEA40, 4'b1111, 1'b1, 1'b1, 0});
        vecs.push_back('{7'h55, 4'b1011, 1'b1,  1, 16'h0000, 4'b0000, 1'b0, 1'b0, 0});
        vecs.push_back('{7'h12, 4'b1110, 1'b0, 10, 16'h0005, 4'b0001, 1'b0, 1'b0, 1});
        vecs.push_back('{7'h24, 4'b1101, 1'b0,  8, 16'h0005, 4'b0001, 1'b0, 1'b0, 0});
        vecs.push_back('{7'h24, 4'b1101, 1'b1,  1, 16'h0000, 4'b0000, 1'b0, 1'b0, 0});
        vecs.push_back('{7'h24, 4'b1101, 1'b0, 10, 16'h0020, 4'b0010, 1'b0, 1'b0, 1});

        bus.seg_in = 7'h7F;
        bus.an_in  = '1;
        bus.clear  = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // First capture latency: pulse on the ninth edge, not before
        for (int i = 1; i <= STB; i++) begin
            step(7'h24, 4'b1110, 1'b0);
            check("latency_no_early_pulse", bus.new_digit, 1'b0);
        end
        step(7'h7F, 4'b1111, 1'b0);
        check("latency_pulse",       bus.new_digit,   1'b1);
        check("latency_data_out",    bus.data_out,    16'h0002);
        check("latency_digit_valid", bus.digit_valid, 4'b0001);
        check("latency_frame_valid", bus.frame_valid, 1'b0);
        step(7'h7F, 4'b1111, 1'b0);
        check("pulse_single_cycle",  bus.new_digit,   1'b0);

        // Directed table
        foreach (vecs[v]) begin
            pulses = 0;
            for (int i = 0; i < vecs[v].hold; i++) begin
                step(vecs[v].seg, vecs[v].an, vecs[v].clr);
                if (bus.new_digit) pulses++;
            end
            check($sformatf("vec%0d_data_out", v),    bus.data_out,    vecs[v].e_data);
            check($sformatf("vec%0d_digit_valid", v), bus.digit_valid, vecs[v].e_valid);
            check($sformatf("vec%0d_frame_valid", v), bus.frame_valid, vecs[v].e_frame);
            check($sformatf("vec%0d_code_err", v),    bus.code_err,    vecs[v].e_err);
            check($sformatf("vec%0d_pulses", v),      pulses,          vecs[v].e_pulses);
        end

        // Reset asserted mid-count: outputs drop immediately
        for (int i = 0; i < 3; i++) step(7'h79, 4'b1110, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // After release a full fresh run is required
        for (int i = 1; i <= STB; i++) begin
            step(7'h79, 4'b1110, 1'b0);
            check("post_reset_no_early_pulse", bus.new_digit, 1'b0);
        end
        step(7'h79, 4'b1110, 1'b0);
        check("post_reset_pulse",    bus.new_digit,   1'b1);
        check("post_reset_data_out", bus.data_out,    16'h0001);
        check("post_reset_valid",    bus.digit_valid, 4'b0001);

        // Randomised bursts against the model
        for (int r = 0; r < 250; r++) begin
            int             h;
            int             sel;
            logic [6:0]     s;
            logic [DIG-1:0] a;
            logic           c;
            logic [DIG-1:0] one;
            h   = $urandom_range(1, 12);
            sel = $urandom_range(0, 9);
            one = 4'b0001;
            if (sel < 7)       a = ~(one << $urandom_range(0, DIG-1));
            else if (sel == 7) a = '1;
            else               a = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 9);
            if (sel < 7)       s = seg_tab[$urandom_range(0, 15)];
            else if (sel == 7) s = 7'h7F;
            else               s = 7'($urandom_range(0, 127));
            c = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < h; i++) step(s, a, c && (i == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
